// File: rtl/bram_data_port_ctrl_pkg.sv
// Shared encodings for the BRAM data-port controller: access sizes, FSM states, lane count.
package bram_data_port_ctrl_pkg;

    localparam int LANE_COUNT = 4;
    localparam int SIZE_WIDTH = 2;

    localparam logic [1:0] SIZE_BYTE    = 2'b00;
    localparam logic [1:0] SIZE_HALF    = 2'b01;
    localparam logic [1:0] SIZE_WORD    = 2'b10;
    localparam logic [1:0] SIZE_ILLEGAL = 2'b11;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_RD   = 3'd1;
    localparam logic [2:0] ST_RDW  = 3'd2;
    localparam logic [2:0] ST_WR   = 3'd3;
    localparam logic [2:0] ST_RESP = 3'd4;

endpackage

// File: rtl/bram_data_port_ctrl_if.sv
// Core-side load/store request and response bundle for the BRAM data-port controller.
interface bram_data_port_ctrl_if
    import bram_data_port_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8
);
    logic                    req_valid;
    logic                    req_ready;
    logic                    req_write;
    logic [SIZE_WIDTH-1:0]   req_size;
    logic                    req_unsigned;
    logic [ADDR_WIDTH+1:0]   req_addr;
    logic [DATA_WIDTH-1:0]   req_wdata;
    logic                    resp_valid;
    logic [DATA_WIDTH-1:0]   resp_rdata;
    logic                    resp_error;

    modport master (
        output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_error
    );

    modport slave (
        input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_error
    );
endinterface

// File: rtl/bram_data_port_ctrl_mem_lane_align.sv
// Combinational lane handling: load extract/extend, sub-word store merge, misalignment detect.
module mem_lane_align
    import bram_data_port_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [1:0]            size,
    input  logic [1:0]            addr_lo,
    input  logic                  is_unsigned,
    input  logic [DATA_WIDTH-1:0] rdata,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] load_data,
    output logic [DATA_WIDTH-1:0] merge_data,
    output logic                  misaligned
);
    localparam int BYTE_W = DATA_WIDTH / LANE_COUNT;
    localparam int HALF_W = 2 * BYTE_W;

    logic [4:0]        byte_shift_s;
    logic [4:0]        half_shift_s;
    logic [BYTE_W-1:0] byte_s;
    logic [HALF_W-1:0] half_s;

    function automatic logic [DATA_WIDTH-1:0] extend_byte(input logic [BYTE_W-1:0] v, input logic uns);
        return uns ? {{(DATA_WIDTH-BYTE_W){1'b0}}, v} : {{(DATA_WIDTH-BYTE_W){v[BYTE_W-1]}}, v};
    endfunction

    function automatic logic [DATA_WIDTH-1:0] extend_half(input logic [HALF_W-1:0] v, input logic uns);
        return uns ? {{(DATA_WIDTH-HALF_W){1'b0}}, v} : {{(DATA_WIDTH-HALF_W){v[HALF_W-1]}}, v};
    endfunction

    assign byte_shift_s = {addr_lo, 3'b000};
    assign half_shift_s = {addr_lo[1], 4'b0000};

    // Pick the addressed byte and half out of the read word.
    always_comb begin
        byte_s = rdata[byte_shift_s +: BYTE_W];
        half_s = rdata[half_shift_s +: HALF_W];
    end

    // Load result, misalignment flag and merged store word per access size.
    always_comb begin
        load_data  = {DATA_WIDTH{1'b0}};
        merge_data = rdata;
        misaligned = 1'b1;
        case (size)
            SIZE_BYTE: begin
                load_data                          = extend_byte(byte_s, is_unsigned);
                merge_data[byte_shift_s +: BYTE_W] = wdata[BYTE_W-1:0];
                misaligned                         = 1'b0;
            end
            SIZE_HALF: begin
                load_data                          = extend_half(half_s, is_unsigned);
                merge_data[half_shift_s +: HALF_W] = wdata[HALF_W-1:0];
                misaligned                         = addr_lo[0];
            end
            SIZE_WORD: begin
                load_data  = rdata;
                merge_data = wdata;
                misaligned = |addr_lo;
            end
            SIZE_ILLEGAL: begin
                misaligned = 1'b1;
            end
            default: begin
                misaligned = 1'b1;
            end
        endcase
    end
endmodule

// File: rtl/bram_data_port_ctrl.sv
// Data-port BRAM controller: serialises core byte/half/word loads and stores into word accesses,
// using read-modify-write for sub-word stores.
module bram_data_port_ctrl
    import bram_data_port_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    bram_data_port_ctrl_if.slave  req_if,
    output logic                  bram_writeEnable,
    output logic [ADDR_WIDTH-1:0] bram_address,
    output logic [DATA_WIDTH-1:0] bram_writeData,
    input  logic [DATA_WIDTH-1:0] bram_readData
);
    logic [2:0]            state_r;
    logic [2:0]            next_state_s;
    logic                  write_r;
    logic [1:0]            size_r;
    logic                  unsigned_r;
    logic [ADDR_WIDTH+1:0] addr_r;
    logic [DATA_WIDTH-1:0] wdata_r;
    logic [DATA_WIDTH-1:0] resp_rdata_r;
    logic                  resp_error_r;

    logic                  idle_s;
    logic                  accept_s;
    logic [1:0]            sel_size_s;
    logic [1:0]            sel_addr_lo_s;
    logic [DATA_WIDTH-1:0] load_data_s;
    logic [DATA_WIDTH-1:0] merge_data_s;
    logic                  misaligned_s;
    logic                  bram_active_s;

    assign idle_s   = (state_r == ST_IDLE);
    assign accept_s = idle_s & req_if.req_valid;

    // Alignment is judged on the live request in IDLE, on the captured one afterwards.
    always_comb begin
        if (idle_s) begin
            sel_size_s    = req_if.req_size;
            sel_addr_lo_s = req_if.req_addr[1:0];
        end else begin
            sel_size_s    = size_r;
            sel_addr_lo_s = addr_r[1:0];
        end
    end

    mem_lane_align #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_align (
        .size        (sel_size_s),
        .addr_lo     (sel_addr_lo_s),
        .is_unsigned (unsigned_r),
        .rdata       (bram_readData),
        .wdata       (wdata_r),
        .load_data   (load_data_s),
        .merge_data  (merge_data_s),
        .misaligned  (misaligned_s)
    );

    // Next-state decode.
    always_comb begin
        next_state_s = ST_IDLE;
        case (state_r)
            ST_IDLE: begin
                if (!req_if.req_valid) begin
                    next_state_s = ST_IDLE;
                end else if (misaligned_s) begin
                    next_state_s = ST_RESP;
                end else if (req_if.req_write && (req_if.req_size == SIZE_WORD)) begin
                    next_state_s = ST_WR;
                end else begin
                    next_state_s = ST_RD;
                end
            end
            ST_RD:   next_state_s = ST_RDW;
            ST_RDW:  next_state_s = write_r ? ST_WR : ST_RESP;
            ST_WR:   next_state_s = ST_RESP;
            ST_RESP: next_state_s = ST_IDLE;
            default: next_state_s = ST_IDLE;
        endcase
    end

    // State, captured request and response registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            write_r      <= 1'b0;
            size_r       <= 2'b00;
            unsigned_r   <= 1'b0;
            addr_r       <= {(ADDR_WIDTH+2){1'b0}};
            wdata_r      <= {DATA_WIDTH{1'b0}};
            resp_rdata_r <= {DATA_WIDTH{1'b0}};
            resp_error_r <= 1'b0;
        end else begin
            state_r <= next_state_s;
            if (accept_s) begin
                write_r      <= req_if.req_write;
                size_r       <= req_if.req_size;
                unsigned_r   <= req_if.req_unsigned;
                addr_r       <= req_if.req_addr;
                wdata_r      <= req_if.req_wdata;
                resp_error_r <= misaligned_s;
                resp_rdata_r <= {DATA_WIDTH{1'b0}};
            end else if ((state_r == ST_RDW) && write_r) begin
                wdata_r <= merge_data_s;
            end else if ((state_r == ST_RDW) && !write_r) begin
                resp_rdata_r <= load_data_s;
            end else if (state_r == ST_RESP) begin
                resp_rdata_r <= {DATA_WIDTH{1'b0}};
                resp_error_r <= 1'b0;
            end else begin
                wdata_r <= wdata_r;
            end
        end
    end

    assign bram_active_s     = (state_r == ST_RD) || (state_r == ST_RDW) || (state_r == ST_WR);
    assign bram_address      = bram_active_s ? addr_r[ADDR_WIDTH+1:2] : {ADDR_WIDTH{1'b0}};
    assign bram_writeEnable  = (state_r == ST_WR);
    assign bram_writeData    = (state_r == ST_WR) ? wdata_r : {DATA_WIDTH{1'b0}};

    assign req_if.req_ready  = idle_s;
    assign req_if.resp_valid = (state_r == ST_RESP);
    assign req_if.resp_rdata = resp_rdata_r;
    assign req_if.resp_error = resp_error_r;
endmodule

// File: tb/tb_bram_data_port_ctrl.sv
// Directed-vector bench for bram_data_port_ctrl with a registered-read BRAM model.
module tb_bram_data_port_ctrl;
    import bram_data_port_ctrl_pkg::*;

    logic        clock;
    logic        reset;
    logic        bram_writeEnable;
    logic [7:0]  bram_address;
    logic [31:0] bram_writeData;
    logic [31:0] bram_readData;
    logic [31:0] mem [0:255];

    int checks;
    int failures;
    int wr_cnt;
    int acc_cnt;
    int resp_cnt;

    bram_data_port_ctrl_if #(.DATA_WIDTH(32), .ADDR_WIDTH(8)) bus ();

    bram_data_port_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(8)) dut (
        .clock            (clock),
        .reset            (reset),
        .req_if           (bus.slave),
        .bram_writeEnable (bram_writeEnable),
        .bram_address     (bram_address),
        .bram_writeData   (bram_writeData),
        .bram_readData    (bram_readData)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // BRAM model: registered read, word write, plus event counters.
    always @(posedge clock) begin
        if (bram_writeEnable) begin
            mem[bram_address] <= bram_writeData;
            wr_cnt <= wr_cnt + 1;
        end
        bram_readData <= mem[bram_address];
        if (bus.req_valid && bus.req_ready) acc_cnt <= acc_cnt + 1;
        if (bus.resp_valid) resp_cnt <= resp_cnt + 1;
    end

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic do_req(input logic wr, input logic [1:0] sz, input logic uns,
                          input logic [9:0] addr, input logic [31:0] wd,
                          output int lat, output logic [31:0] rd, output logic er,
                          output int busy_ready);
        @(negedge clock);
        bus.req_valid    = 1'b1;
        bus.req_write    = wr;
        bus.req_size     = sz;
        bus.req_unsigned = uns;
        bus.req_addr     = addr;
        bus.req_wdata    = wd;
        @(posedge clock);
        #1 bus.req_valid = 1'b0;
        lat = 0; busy_ready = 0; rd = 32'h0; er = 1'b0;
        while (lat < 20) begin
            @(negedge clock);
            lat++;
            if (bus.req_ready) busy_ready++;
            if (bus.resp_valid) begin
                rd = bus.resp_rdata;
                er = bus.resp_error;
                break;
            end
        end
    endtask

    typedef struct {
        string       tag;
        logic        wr;
        logic [1:0]  sz;
        logic        uns;
        logic [9:0]  addr;
        logic [31:0] wd;
        int          lat;
        logic [31:0] rdata;
        logic        err;
        int          writes;
    } vec_t;

    vec_t vecs [$];

    initial begin
        int          lat;
        int          busy;
        int          w0;
        int          a0;
        int          r0;
        logic [31:0] rd;
        logic        er;

        checks = 0; failures = 0; wr_cnt = 0; acc_cnt = 0; resp_cnt = 0;
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        bram_readData    = 32'h0;
        bus.req_valid    = 1'b0;
        bus.req_write    = 1'b0;
        bus.req_size     = 2'b00;
        bus.req_unsigned = 1'b0;
        bus.req_addr     = 10'h0;
        bus.req_wdata    = 32'h0;
        reset = 1'b1;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check_value("rst_ready",  {31'h0, bus.req_ready},      32'h1);
        check_value("rst_rvalid", {31'h0, bus.resp_valid},     32'h0);
        check_value("rst_rdata",  bus.resp_rdata,              32'h0);
        check_value("rst_rerr",   {31'h0, bus.resp_error},     32'h0);
        check_value("rst_we",     {31'h0, bram_writeEnable},   32'h0);
        check_value("rst_addr",   {24'h0, bram_address},       32'h0);
        check_value("rst_wdata",  bram_writeData,              32'h0);
        reset = 1'b0;
        @(negedge clock);
        check_value("post_rst_ready", {31'h0, bus.req_ready},  32'h1);

        // Word store/load, then sub-word RMW over a preloaded word, then extends and errors.
        vecs.push_back('{"st_w_dead", 1'b1, SIZE_WORD, 1'b0, 10'h010, 32'hDEADBEEF, 2, 32'h0,        1'b0, 1});
        vecs.push_back('{"ld_w_dead", 1'b0, SIZE_WORD, 1'b0, 10'h010, 32'h0,        3, 32'hDEADBEEF, 1'b0, 0});
        foreach (vecs[i]) begin
            w0 = wr_cnt;
            do_req(vecs[i].wr, vecs[i].sz, vecs[i].uns, vecs[i].addr, vecs[i].wd, lat, rd, er, busy);
            check_value({vecs[i].tag, "_lat"},   32'(lat),           32'(vecs[i].lat));
            check_value({vecs[i].tag, "_rdata"}, rd,                 vecs[i].rdata);
            check_value({vecs[i].tag, "_err"},   {31'h0, er},        {31'h0, vecs[i].err});
            check_value({vecs[i].tag, "_wr"},    32'(wr_cnt - w0),   32'(vecs[i].writes));
            check_value({vecs[i].tag, "_busy"},  32'(busy),          32'h0);
        end
        check_value("mem4_dead", mem[4], 32'hDEADBEEF);

        @(negedge clock);
        mem[4] = 32'h11223344;
        vecs.delete();
        vecs.push_back('{"st_b_a5",   1'b1, SIZE_BYTE, 1'b0, 10'h013, 32'h000000A5, 4, 32'h0,        1'b0, 1});
        vecs.push_back('{"ld_w_a5",   1'b0, SIZE_WORD, 1'b0, 10'h010, 32'h0,        3, 32'hA5223344, 1'b0, 0});
        vecs.push_back('{"ld_bs_13",  1'b0, SIZE_BYTE, 1'b0, 10'h013, 32'h0,        3, 32'hFFFFFFA5, 1'b0, 0});
        vecs.push_back('{"ld_bu_13",  1'b0, SIZE_BYTE, 1'b1, 10'h013, 32'h0,        3, 32'h000000A5, 1'b0, 0});
        vecs.push_back('{"ld_hs_12",  1'b0, SIZE_HALF, 1'b0, 10'h012, 32'h0,        3, 32'hFFFFA522, 1'b0, 0});
        vecs.push_back('{"ld_hu_10",  1'b0, SIZE_HALF, 1'b1, 10'h010, 32'h0,        3, 32'h00003344, 1'b0, 0});
        vecs.push_back('{"ld_bs_10",  1'b0, SIZE_BYTE, 1'b0, 10'h010, 32'h0,        3, 32'h00000044, 1'b0, 0});
        vecs.push_back('{"ld_bs_11",  1'b0, SIZE_BYTE, 1'b0, 10'h011, 32'h0,        3, 32'h00000033, 1'b0, 0});
        vecs.push_back('{"st_h_beef", 1'b1, SIZE_HALF, 1'b0, 10'h012, 32'h1234BEEF, 4, 32'h0,        1'b0, 1});
        vecs.push_back('{"ld_w_beef", 1'b0, SIZE_WORD, 1'b0, 10'h010, 32'h0,        3, 32'hBEEF3344, 1'b0, 0});
        vecs.push_back('{"err_h_st",  1'b1, SIZE_HALF, 1'b0, 10'h011, 32'hFFFFFFFF, 1, 32'h0,        1'b1, 0});
        vecs.push_back('{"err_w_ld",  1'b0, SIZE_WORD, 1'b0, 10'h002, 32'h0,        1, 32'h0,        1'b1, 0});
        vecs.push_back('{"err_sz3",   1'b1, 2'b11,     1'b0, 10'h010, 32'hFFFFFFFF, 1, 32'h0,        1'b1, 0});
        vecs.push_back('{"ld_w_after",1'b0, SIZE_WORD, 1'b0, 10'h010, 32'h0,        3, 32'hBEEF3344, 1'b0, 0});
        foreach (vecs[i]) begin
            w0 = wr_cnt;
            do_req(vecs[i].wr, vecs[i].sz, vecs[i].uns, vecs[i].addr, vecs[i].wd, lat, rd, er, busy);
            check_value({vecs[i].tag, "_lat"},   32'(lat),           32'(vecs[i].lat));
            check_value({vecs[i].tag, "_rdata"}, rd,                 vecs[i].rdata);
            check_value({vecs[i].tag, "_err"},   {31'h0, er},        {31'h0, vecs[i].err});
            check_value({vecs[i].tag, "_wr"},    32'(wr_cnt - w0),   32'(vecs[i].writes));
            check_value({vecs[i].tag, "_busy"},  32'(busy),          32'h0);
        end
        check_value("mem4_final", mem[4], 32'hBEEF3344);
        check_value("mem0_untouched", mem[0], 32'h0);

        // Back-to-back: req_valid held for 8 edges -> accepts at edges 0 and 4 only.
        @(negedge clock);
        a0 = acc_cnt; r0 = resp_cnt;
        bus.req_valid    = 1'b1;
        bus.req_write    = 1'b0;
        bus.req_size     = SIZE_WORD;
        bus.req_unsigned = 1'b0;
        bus.req_addr     = 10'h010;
        repeat (8) @(posedge clock);
        #1 bus.req_valid = 1'b0;
        repeat (6) @(negedge clock);
        check_value("b2b_accepts", 32'(acc_cnt - a0),  32'd2);
        check_value("b2b_resps",   32'(resp_cnt - r0), 32'd2);
        check_value("b2b_ready",   {31'h0, bus.req_ready}, 32'h1);

        // Reset while a byte store sits in WR.
        mem[8] = 32'h55667788;
        w0 = wr_cnt; r0 = resp_cnt;
        bus.req_valid    = 1'b1;
        bus.req_write    = 1'b1;
        bus.req_size     = SIZE_BYTE;
        bus.req_addr     = 10'h021;
        bus.req_wdata    = 32'h00000099;
        @(posedge clock);
        #1 bus.req_valid = 1'b0;
        repeat (3) @(negedge clock);
        check_value("rmw_we_in_wr",   {31'h0, bram_writeEnable}, 32'h1);
        check_value("rmw_addr_in_wr", {24'h0, bram_address},     32'h8);
        check_value("rmw_data_in_wr", bram_writeData,            32'h55669988);
        reset = 1'b1;
        #1;
        check_value("abort_we_fall",  {31'h0, bram_writeEnable}, 32'h0);
        check_value("abort_rvalid",   {31'h0, bus.resp_valid},   32'h0);
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        repeat (3) @(negedge clock);
        check_value("abort_mem",   mem[8],                   32'h55667788);
        check_value("abort_wr",    32'(wr_cnt - w0),         32'h0);
        check_value("abort_resp",  32'(resp_cnt - r0),       32'h0);
        check_value("abort_ready", {31'h0, bus.req_ready},   32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
